// File: rtl/micro_sequencer_if.sv
// Handshake bundle between the micro-sequencer, the control store, the IR map ROM
// and the memory interface. The master side drives control-word and memory inputs.
interface micro_sequencer_if #(
   parameter int AW = 5
);
   logic          start;
   logic [AW-1:0] ir_map;
   logic [AW-1:0] naddr;
   logic          br;
   logic          z;
   logic          mwait;
   logic          fin;
   logic          mem_rdy;
   logic [AW-1:0] car;
   logic          busy;
   logic          mem_req;
   logic          done;
   logic          err;

   modport master (
      output start, ir_map, naddr, br, z, mwait, fin, mem_rdy,
      input  car, busy, mem_req, done, err
   );

   modport slave (
      input  start, ir_map, naddr, br, z, mwait, fin, mem_rdy,
      output car, busy, mem_req, done, err
   );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the CAR, runs IDLE/RUN/WAIT_MEM and stalls on memory.
// Optional memory-wait watchdog compiled in with MICRO_SEQ_WATCHDOG_EN.
module micro_sequencer #(
   parameter int          AW         = 5,
   parameter logic [AW-1:0] START_ADDR = 5'b00000,
   parameter logic [AW-1:0] FETCH_ADDR = 5'b00001,
   parameter logic [AW-1:0] JMPZ_ADDR  = 5'b01001,
   parameter logic [AW-1:0] SKIP_ADDR  = 5'b01011,
   parameter int          TIMEOUT    = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   micro_sequencer_if.slave       bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2
`ifdef MICRO_SEQ_WATCHDOG_EN
      ,S_ERR = 2'd3
`endif
   } state_t;

   state_t        state_q;
   logic [AW-1:0] car_q;
   logic          busy_q;
   logic          mem_req_q;
   logic          done_q;
   logic [AW-1:0] na_d;

   // The conditional-jump routine short-circuits to its exit when Z is set.
   always_comb begin
      na_d = bus.naddr;
      if (bus.br) begin
         if (bus.z && (bus.ir_map == JMPZ_ADDR)) na_d = SKIP_ADDR;
         else                                    na_d = bus.ir_map;
      end
   end

`ifdef MICRO_SEQ_WATCHDOG_EN
   localparam int WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0] wd_q;
   logic           err_q;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         car_q     <= START_ADDR;
         busy_q    <= 1'b0;
         mem_req_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef MICRO_SEQ_WATCHDOG_EN
         wd_q      <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q <= S_RUN;
                  car_q   <= FETCH_ADDR;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               if (bus.mwait) begin
                  state_q   <= S_WAIT;
                  mem_req_q <= 1'b1;
`ifdef MICRO_SEQ_WATCHDOG_EN
                  wd_q      <= '0;
`endif
               end else if (bus.fin) begin
                  state_q <= S_IDLE;
                  car_q   <= START_ADDR;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  car_q <= na_d;
               end
            end
            S_WAIT: begin
               // Completion takes priority over the watchdog expiring in the same cycle.
               if (bus.mem_rdy) begin
                  mem_req_q <= 1'b0;
                  if (bus.fin) begin
                     state_q <= S_IDLE;
                     car_q   <= START_ADDR;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                     car_q   <= na_d;
                  end
               end
`ifdef MICRO_SEQ_WATCHDOG_EN
               else if (wd_q == WDW'(TIMEOUT - 1)) begin
                  state_q   <= S_ERR;
                  car_q     <= START_ADDR;
                  busy_q    <= 1'b0;
                  mem_req_q <= 1'b0;
                  err_q     <= 1'b1;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.car     = car_q;
   assign bus.busy    = busy_q;
   assign bus.mem_req = mem_req_q;
   assign bus.done    = done_q;
`ifdef MICRO_SEQ_WATCHDOG_EN
   assign bus.err     = err_q;
`else
   assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus a randomized run
// compared against a lifecycle-level reference model.
module tb_micro_sequencer;
   localparam int AW      = 5;
   localparam int TIMEOUT = 16;
   localparam logic [4:0] JMPZ = 5'b01001;
   localparam logic [4:0] SKIP = 5'b01011;

   logic clk = 1'b0;
   logic rstn;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   micro_sequencer_if #(.AW(AW)) bus ();

   micro_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   // Reference model: lifecycle phase, expected CAR, done pulse, memory-wait age.
   typedef enum int {M_IDLE, M_RUN, M_WAIT, M_ERR} mode_t;
   mode_t    m_mode;
   logic [4:0] m_car;
   logic     m_done;
   int       m_age;

   function automatic logic [4:0] ref_next();
      if (!bus.br) return bus.naddr;
      if (bus.z && bus.ir_map == JMPZ) return SKIP;
      return bus.ir_map;
   endfunction

   task automatic model_step();
      logic [4:0] na;
      na = ref_next();
      if (!rstn) begin
         m_mode = M_IDLE; m_car = 5'd0; m_done = 1'b0; m_age = 0;
         return;
      end
      m_done = 1'b0;
      if (m_mode == M_IDLE) begin
         if (bus.start) begin m_mode = M_RUN; m_car = 5'd1; end
      end else if (m_mode == M_RUN || (m_mode == M_WAIT && bus.mem_rdy)) begin
         if (m_mode == M_RUN && bus.mwait) begin
            m_mode = M_WAIT; m_age = 0;
         end else if (bus.fin) begin
            m_mode = M_IDLE; m_car = 5'd0; m_done = 1'b1;
         end else begin
            m_mode = M_RUN; m_car = na;
         end
      end else if (m_mode == M_WAIT) begin
`ifdef MICRO_SEQ_WATCHDOG_EN
         m_age++;
         if (m_age >= TIMEOUT) begin m_mode = M_ERR; m_car = 5'd0; end
`endif
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.start = 0; bus.ir_map = 0; bus.naddr = 0; bus.br = 0; bus.z = 0;
      bus.mwait = 0; bus.fin = 0; bus.mem_rdy = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rstn = 1'b0;
      tick(); tick();
      rstn = 1'b1;
      checks++; if (bus.car !== 5'd0) begin errors++; $display("FAIL reset_car got %b exp 00000", bus.car); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", bus.mem_req); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
   endtask

   task automatic test_next_addr();
      bus.start = 1; tick(); bus.start = 0;
      checks++; if (bus.car !== 5'b00001 || bus.busy !== 1'b1) begin errors++; $display("FAIL start_fetch got car %b busy %b exp 00001 1", bus.car, bus.busy); end
      bus.br = 0; bus.naddr = 5'b00110; tick();
      checks++; if (bus.car !== 5'b00110) begin errors++; $display("FAIL naddr got %b exp 00110", bus.car); end
      bus.br = 1; bus.ir_map = 5'b01001; bus.z = 1; tick();
      checks++; if (bus.car !== 5'b01011) begin errors++; $display("FAIL jmpz_taken got %b exp 01011", bus.car); end
      bus.z = 0; tick();
      checks++; if (bus.car !== 5'b01001) begin errors++; $display("FAIL jmpz_not_taken got %b exp 01001", bus.car); end
      bus.ir_map = 5'b00100; bus.z = 1; tick();
      checks++; if (bus.car !== 5'b00100) begin errors++; $display("FAIL map_other got %b exp 00100", bus.car); end
      bus.br = 0;
   endtask

   task automatic test_mem_wait();
      bus.naddr = 5'b00010; tick();
      checks++; if (bus.car !== 5'b00010) begin errors++; $display("FAIL mem_setup got %b exp 00010", bus.car); end
      bus.mwait = 1; bus.naddr = 5'b00101;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.mem_req !== 1'b1 || bus.car !== 5'b00010 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL mem_hold cyc %0d got req %b car %b busy %b exp 1 00010 1", i, bus.mem_req, bus.car, bus.busy);
         end
      end
      bus.mem_rdy = 1; tick();
      checks++; if (bus.mem_req !== 1'b0 || bus.car !== 5'b00101) begin errors++; $display("FAIL mem_done got req %b car %b exp 0 00101", bus.mem_req, bus.car); end
      bus.mem_rdy = 0; bus.mwait = 0;
   endtask

   task automatic test_fin_wait();
      bus.mwait = 1; bus.fin = 1; tick();
      checks++; if (bus.mem_req !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL fin_wait_enter got req %b done %b exp 1 0", bus.mem_req, bus.done); end
      bus.mem_rdy = 1; tick();
      checks++; if (bus.car !== 5'd0 || bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.mem_req !== 1'b0) begin
         errors++; $display("FAIL fin_wait_exit got car %b busy %b done %b req %b exp 00000 0 1 0", bus.car, bus.busy, bus.done, bus.mem_req);
      end
      clear_inputs(); bus.start = 1; tick(); bus.start = 0;
      checks++; if (bus.done !== 1'b0 || bus.car !== 5'd1 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL done_pulse_restart got done %b car %b busy %b exp 0 00001 1", bus.done, bus.car, bus.busy);
      end
   endtask

   task automatic test_reset_in_wait();
      bus.mwait = 1; tick(); bus.mwait = 0;
      rstn = 0; tick(); rstn = 1;
      checks++; if (bus.car !== 5'd0 || bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_wait got car %b req %b busy %b exp 00000 0 0", bus.car, bus.mem_req, bus.busy);
      end
      bus.start = 1; tick();
      bus.naddr = 5'b00111; tick();
      checks++; if (bus.car !== 5'b00111 || bus.busy !== 1'b1) begin errors++; $display("FAIL start_in_run got car %b busy %b exp 00111 1", bus.car, bus.busy); end
      clear_inputs(); bus.fin = 1; tick(); clear_inputs();
   endtask

   task automatic test_random();
      logic [4:0] exp_v, got_v;
      clear_inputs(); rstn = 0; tick(); rstn = 1;
      for (int c = 0; c < 600; c++) begin
         rstn        = ($urandom_range(0, 59) != 0);
         bus.start   = $urandom_range(0, 1);
         bus.br      = $urandom_range(0, 1);
         bus.z       = $urandom_range(0, 1);
         bus.ir_map  = ($urandom_range(0, 2) == 0) ? JMPZ : 5'($urandom);
         bus.naddr   = 5'($urandom);
         bus.mwait   = ($urandom_range(0, 3) == 0);
         bus.fin     = ($urandom_range(0, 7) == 0);
         bus.mem_rdy = $urandom_range(0, 1);
         tick();
         exp_v = {m_mode == M_RUN || m_mode == M_WAIT, m_mode == M_WAIT, m_done, m_mode == M_ERR, 1'b0};
         got_v = {bus.busy, bus.mem_req, bus.done, bus.err, 1'b0};
         checks++;
         if (got_v !== exp_v || bus.car !== m_car) begin
            errors++; $display("FAIL random cyc %0d got car %b flags %b exp car %b flags %b", c, bus.car, got_v, m_car, exp_v);
         end
      end
      rstn = 1; clear_inputs();
   endtask

`ifdef MICRO_SEQ_WATCHDOG_EN
   task automatic test_watchdog();
      clear_inputs(); rstn = 0; tick(); rstn = 1;
      bus.start = 1; tick(); bus.start = 0;
      bus.mwait = 1; tick();
      for (int i = 1; i < TIMEOUT; i++) tick();
      checks++; if (bus.err !== 1'b0 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL wd_early got err %b req %b exp 0 1", bus.err, bus.mem_req); end
      tick();
      checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.car !== 5'd0) begin
         errors++; $display("FAIL wd_expire got err %b busy %b req %b car %b exp 1 0 0 00000", bus.err, bus.busy, bus.mem_req, bus.car);
      end
      bus.start = 1; bus.mem_rdy = 1; tick(); tick();
      checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL wd_sticky got err %b busy %b exp 1 0", bus.err, bus.busy); end
      clear_inputs(); rstn = 0; tick(); rstn = 1;
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL wd_reset got err %b exp 0", bus.err); end
      bus.start = 1; tick(); bus.start = 0;
      bus.mwait = 1; bus.naddr = 5'b00011; tick();
      for (int i = 1; i < TIMEOUT; i++) tick();
      bus.mem_rdy = 1; tick();
      checks++; if (bus.err !== 1'b0 || bus.car !== 5'b00011 || bus.busy !== 1'b1 || bus.mem_req !== 1'b0) begin
         errors++; $display("FAIL wd_last_cycle got err %b car %b busy %b req %b exp 0 00011 1 0", bus.err, bus.car, bus.busy, bus.mem_req);
      end
      clear_inputs();
   endtask
`endif

   initial begin
      m_mode = M_IDLE; m_car = 5'd0; m_done = 1'b0; m_age = 0;
      rstn = 1'b0;
      test_reset();
      test_next_addr();
      test_mem_wait();
      test_fin_wait();
      test_reset_in_wait();
`ifdef MICRO_SEQ_WATCHDOG_EN
      test_watchdog();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer for the control unit. Owns the control address register (CAR) that indexes the control store and applies the next-address decision each cycle. Runs a START/FETCH/RUN lifecycle and stalls the microprogram on a memory handshake. Sits between the control store (whose word supplies `naddr`, `br`, `mwait`, `fin`), the IR map ROM, and the memory interface.

## Interface
Parameters:
- `AW`, 5: control store address width.
- `START_ADDR`, 5'b00000: idle/start microaddress.
- `FETCH_ADDR`, 5'b00001: first microaddress after `start`.
- `JMPZ_ADDR`, 5'b01001: mapped address of the conditional-jump routine.
- `SKIP_ADDR`, 5'b01011: microaddress that exits the jump routine when Z=1.
- `TIMEOUT`, 16: memory-wait watchdog limit in cycles (≥2).

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rstn`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin execution; sampled only in IDLE.
- `ir_map`, in, AW: mapped IR address.
- `naddr`, in, AW: next-address field of the current control word.
- `br`, in, 1: branch-to-map field of the current control word.
- `z`, in, 1: ALU zero flag.
- `mwait`, in, 1: the current microinstruction needs memory.
- `fin`, in, 1: the current microinstruction ends the program.
- `mem_rdy`, in, 1: memory completion.
- `car`, out, AW: control store address.
- `busy`, out, 1: high in RUN and WAIT_MEM.
- `mem_req`, out, 1: high in WAIT_MEM.
- `done`, out, 1: one-cycle pulse after the program finishes.
- `err`, out, 1: watchdog error (see Configuration).

## Operation
- Next-address function NA:
  - `br`=0 → `naddr`.
  - `br`=1, `z`=1 and `ir_map`==JMPZ_ADDR → SKIP_ADDR.
  - Otherwise `br`=1 → `ir_map`.
- States and transitions:
  - IDLE: `car`=START_ADDR. `start`=1 → RUN with `car`←FETCH_ADDR. `start` is ignored in every other state.
  - RUN, checked in priority order:
    - `mwait`=1 → WAIT_MEM; `car` holds.
    - else `fin`=1 → IDLE; `car`←START_ADDR; `done`=1 next cycle.
    - else `car`←NA; stay in RUN.
  - WAIT_MEM: `car` holds and the control word stays stable. `mem_rdy`=1 → apply the RUN advance rules ignoring `mwait`: `fin`=1 → IDLE with `done`, else `car`←NA and go to RUN. `mem_rdy` is ignored outside WAIT_MEM.
  - ERR (only with the watchdog compiled in): `car`=START_ADDR, `busy`=0, `mem_req`=0, `err`=1. Left only by reset.
- Reset: `rstn`=0 at an edge forces IDLE from any state, including mid-WAIT_MEM. Reset values: `car`=START_ADDR; `busy`, `mem_req`, `done`, `err`=0; watchdog counter=0.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Timing
- `start` at edge k → `car`=FETCH_ADDR and `busy`=1 after edge k.
- Non-memory microinstruction: exactly 1 cycle per microinstruction.
- Memory microinstruction: `mwait` seen at edge k. `mem_req`=1 from k+1. `mem_rdy` seen at edge k+n (n≥1) → `car` advances and `mem_req`=0 after k+n. Minimum 2 cycles.
- `fin` at edge k → IDLE, `busy`=0, `done`=1 after k. `done` clears after k+1. `start` is accepted again at k+1.
- `mem_rdy` held high across consecutive memory microinstructions: each one still spends ≥1 cycle in WAIT_MEM.

## Configuration
- `MICRO_SEQ_WATCHDOG_EN` defined:
  - A counter clears on WAIT_MEM entry and increments each WAIT_MEM cycle without `mem_rdy`.
  - After TIMEOUT such cycles → ERR.
  - If `mem_rdy` arrives in the TIMEOUT-th cycle, completion wins.
- Not defined: no counter and no ERR state. WAIT_MEM waits indefinitely, and `err` is tied to 0.

## Test plan
- Reset then `start`=1 → `car`=5'b00001, `busy`=1. Then `br`=0, `naddr`=5'b00110 → `car`=5'b00110 next cycle.
- `br`=1, `ir_map`=5'b01001, `z`=1 → `car`=5'b01011. Repeat with `z`=0 → `car`=5'b01001. With `ir_map`=5'b00100 and `z`=1 → `car`=5'b00100.
- `mwait`=1 at `car`=5'b00010, `mem_rdy` raised after 3 cycles → `mem_req`=1 for 3 cycles and `car` holds 5'b00010. It then advances to `naddr` and `mem_req`=0.
- `mwait`=1 and `fin`=1 together, `mem_rdy` after 1 cycle → WAIT_MEM, then IDLE with `car`=5'b00000, one `done` pulse, `busy`=0.
- `rstn`=0 during WAIT_MEM → next cycle IDLE, `car`=5'b00000, `mem_req`=0. A `start` while RUN has no effect.
- With `MICRO_SEQ_WATCHDOG_EN`, TIMEOUT=16, no `mem_rdy` → `err`=1 after 16 WAIT_MEM cycles and stays until reset. Separately, `mem_rdy` in cycle 16 → normal advance with `err`=0.
